// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: header-tagged byte storage with read-side packet tracking.
// Optional sticky overflow flag enabled by defining ROUTER_FIFO_OVF_EN.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [6:0]       pkt_count_q, pkt_count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH:0]   rd_word;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign wr_fire  = write_enb && !full && !soft_reset;
    assign rd_fire  = read_enb && !empty && !soft_reset;
    assign rd_word  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        data_out_d  = data_out_q;
        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            data_out_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[WIDTH-1:0];
                // Header length field counts payload only; +1 covers the trailing parity byte.
                if (rd_word[WIDTH]) begin
                    pkt_count_d = {1'b0, rd_word[7:2]} + 7'd1;
                end else if (pkt_count_q != '0) begin
                    pkt_count_d = pkt_count_q - 7'd1;
                end
            end else if (pkt_count_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage is never cleared; reset only moves the pointers.
    always_ff @(posedge clock) begin
        if (resetn && wr_fire) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

`ifdef ROUTER_FIFO_OVF_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (soft_reset) begin
            overflow_d = 1'b0;
        end else if (write_enb && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: vector table for packet flows and resets, loops for full/wrap corners.
// Overflow expectations follow ROUTER_FIFO_OVF_EN.
module tb_router_fifo;

`ifdef ROUTER_FIFO_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rn;
        logic       sr;
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       fl;
        logic       em;
    } vec_t;

    vec_t vq[$];

    router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic rn, input logic sr, input logic we, input logic re,
                         input logic lfd, input logic [7:0] din);
        resetn     = rn;
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        @(posedge clock);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input string n, input logic rn, input logic sr, input logic we,
                       input logic re, input logic lfd, input logic [7:0] din,
                       input logic [7:0] dout, input logic fl, input logic em);
        vec_t v;
        v.name = n; v.rn = rn; v.sr = sr; v.we = we; v.re = re; v.lfd = lfd;
        v.din = din; v.dout = dout; v.fl = fl; v.em = em;
        vq.push_back(v);
    endtask

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;

        //  name        rn sr we re lfd din    dout   fl em
        add("reset",    0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        add("w_hdr0d",  1, 0, 1, 0, 1, 8'h0D, 8'h00, 0, 0);
        add("w_p11",    1, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0);
        add("w_p22",    1, 0, 1, 0, 0, 8'h22, 8'h00, 0, 0);
        add("w_p33",    1, 0, 1, 0, 0, 8'h33, 8'h00, 0, 0);
        add("w_parA5",  1, 0, 1, 0, 0, 8'hA5, 8'h00, 0, 0);
        add("r_hdr0d",  1, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0);
        add("r_p11",    1, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0);
        add("r_p22",    1, 0, 0, 1, 0, 8'h00, 8'h22, 0, 0);
        add("r_p33",    1, 0, 0, 1, 0, 8'h00, 8'h33, 0, 0);
        add("r_parA5",  1, 0, 0, 1, 0, 8'h00, 8'hA5, 0, 1);
        add("idle0",    1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        // header 09: length 2, so the output must hold mid-packet while empty
        add("w_hdr09",  1, 0, 1, 0, 1, 8'h09, 8'h00, 0, 0);
        add("r_hdr09",  1, 0, 0, 1, 0, 8'h00, 8'h09, 0, 1);
        add("wr_empty", 1, 0, 1, 1, 0, 8'h44, 8'h09, 0, 0);
        add("w_p55",    1, 0, 1, 0, 0, 8'h55, 8'h09, 0, 0);
        add("w_parC3",  1, 0, 1, 0, 0, 8'hC3, 8'h09, 0, 0);
        add("r_p44",    1, 0, 0, 1, 0, 8'h00, 8'h44, 0, 0);
        add("r_p55",    1, 0, 0, 1, 0, 8'h00, 8'h55, 0, 0);
        add("r_parC3",  1, 0, 0, 1, 0, 8'h00, 8'hC3, 0, 1);
        add("idle1",    1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        add("w6_05",    1, 0, 1, 0, 1, 8'h05, 8'h00, 0, 0);
        add("w6_66",    1, 0, 1, 0, 0, 8'h66, 8'h00, 0, 0);
        add("w6_77",    1, 0, 1, 0, 0, 8'h77, 8'h00, 0, 0);
        add("w6_88",    1, 0, 1, 0, 0, 8'h88, 8'h00, 0, 0);
        add("w6_99",    1, 0, 1, 0, 0, 8'h99, 8'h00, 0, 0);
        add("w6_AA",    1, 0, 1, 0, 0, 8'hAA, 8'h00, 0, 0);
        add("r2_05",    1, 0, 0, 1, 0, 8'h00, 8'h05, 0, 0);
        add("r2_66",    1, 0, 0, 1, 0, 8'h00, 8'h66, 0, 0);
        add("soft_rst", 1, 1, 1, 1, 0, 8'hEE, 8'h00, 0, 1);
        add("sw_hdr05", 1, 0, 1, 0, 1, 8'h05, 8'h00, 0, 0);
        add("sw_12",    1, 0, 1, 0, 0, 8'h12, 8'h00, 0, 0);
        add("sw_34",    1, 0, 1, 0, 0, 8'h34, 8'h00, 0, 0);
        add("sr_hdr05", 1, 0, 0, 1, 0, 8'h00, 8'h05, 0, 0);
        add("sr_12",    1, 0, 0, 1, 0, 8'h00, 8'h12, 0, 0);
        add("sr_34",    1, 0, 0, 1, 0, 8'h00, 8'h34, 0, 1);
        add("idle2",    1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        add("m_hdr0d",  1, 0, 1, 0, 1, 8'h0D, 8'h00, 0, 0);
        add("m_p01",    1, 0, 1, 0, 0, 8'h01, 8'h00, 0, 0);
        add("m_rhdr",   1, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0);
        add("hard_rst", 0, 1, 1, 1, 0, 8'h77, 8'h00, 0, 1);
        add("w3c",      1, 0, 1, 1, 0, 8'h3C, 8'h00, 0, 0);
        add("r3c",      1, 0, 0, 1, 0, 8'h00, 8'h3C, 0, 1);
        add("idle3",    1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i].rn, vq[i].sr, vq[i].we, vq[i].re, vq[i].lfd, vq[i].din);
            chk8({vq[i].name, "_dout"}, data_out, vq[i].dout);
            chk1({vq[i].name, "_full"}, full, vq[i].fl);
            chk1({vq[i].name, "_empty"}, empty, vq[i].em);
            chk1({vq[i].name, "_ovf"}, overflow, 1'b0);
        end

        // Fill to full, attempt a 17th write, drain in order.
        drive(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1, 0, 0, 8'(8'h10 + i));
            chk1("fill_full", full, i == 15);
        end
        drive(1, 0, 1, 0, 0, 8'hFF);
        chk1("full_drop_full", full, 1'b1);
        chk1("full_drop_ovf", overflow, OVF_ON);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, 0, 8'h00);
            chk8("drain_dout", data_out, 8'(8'h10 + i));
            chk1("drain_empty", empty, i == 15);
        end
        chk1("ovf_sticky", overflow, OVF_ON);

        // Full with simultaneous read: read proceeds, write dropped.
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 0, 0, 8'(8'h20 + i));
        chk1("refill_full", full, 1'b1);
        drive(1, 0, 1, 1, 0, 8'hFE);
        chk8("full_rw_dout", data_out, 8'h20);
        chk1("full_rw_full", full, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1, 0, 0, 1, 0, 8'h00);
            chk8("full_rw_drain", data_out, 8'(8'h20 + i));
        end
        chk1("full_rw_empty", empty, 1'b1);
        drive(1, 0, 0, 0, 0, 8'h00);
        chk8("full_rw_idle", data_out, 8'h00);
        drive(1, 1, 0, 0, 0, 8'h00);
        chk1("sr_ovf_clear", overflow, 1'b0);
        chk1("sr_empty", empty, 1'b1);

        // Steady-state streaming at occupancy 10 across pointer wrap.
        drive(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, 0, 0, 8'(8'h40 + i));
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 1, 1, 0, 8'(8'h4A + k));
            chk8("stream_dout", data_out, 8'(8'h40 + k));
            chk1("stream_full", full, 1'b0);
            chk1("stream_empty", empty, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 1, 0, 8'h00);
            chk8("stream_tail", data_out, 8'(8'h54 + i));
        end
        chk1("stream_end_empty", empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
